// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if
// Request/result bundle for the sequential binary-to-BCD converter.
//   I_Start  requester -> converter  conversion request (taken only when idle)
//   I_Bin    requester -> converter  32-bit unsigned value to convert
//   O_Busy   converter -> requester  conversion in progress
//   O_Done   converter -> requester  one-cycle strobe, result valid
//   O_Bcd    converter -> requester  8 packed BCD digits, [3:0] least significant
//   O_Ovf    converter -> requester  value exceeded 99,999,999
// ---------------------------------------------------------------------------
interface bin2bcd_seq_if;
  logic        I_Start;
  logic [31:0] I_Bin;
  logic        O_Busy;
  logic        O_Done;
  logic [31:0] O_Bcd;
  logic        O_Ovf;

  modport master (
    output I_Start, I_Bin,
    input  O_Busy, O_Done, O_Bcd, O_Ovf
  );

  modport slave (
    input  I_Start, I_Bin,
    output O_Busy, O_Done, O_Bcd, O_Ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential 32-bit binary to BCD converter (shift-and-add-3, one bit per
// clock). A conversion takes 32 SHIFT cycles followed by one DONE cycle.
// Ports:
//   Clk    system clock, rising edge
//   Reset  asynchronous, active-high reset
//   bus    bin2bcd_seq_if.slave (I_Start, I_Bin in; O_Busy, O_Done, O_Bcd,
//          O_Ovf out)
// Parameter:
//   SATURATE  1: overflowing values read as 32'h99999999
//             0: overflowing values show their low 8 decimal digits
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter bit SATURATE = 1'b1
) (
  input  logic          Clk,
  input  logic          Reset,
  bin2bcd_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [39:0] acc_q, acc_d;      // 10 BCD digits; digits 9..8 flag overflow
  logic [31:0] bin_q, bin_d;
  logic [31:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;

  logic [39:0] acc_corr;
  logic [39:0] acc_shift;
  logic        ovf_next;

  // Add-3 correction on every digit >= 5 so the following doubling carries
  // correctly into the next decimal digit.
  always_comb begin
    acc_corr = acc_q;
    for (int i = 0; i < 10; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_corr[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Accumulator and binary register shift as one 72-bit word.
  assign acc_shift = {acc_corr[38:0], bin_q[31]};
  assign ovf_next  = |acc_shift[39:32];

  // NOTE: every variable gets its hold value before the case statement, so
  // no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.I_Start) begin
          bin_d   = bus.I_Bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        acc_d = acc_shift;
        bin_d = {bin_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        // Counter reads 31 on the edge that performs the 32nd shift.
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          ovf_d   = ovf_next;
          bcd_d   = (SATURATE && ovf_next) ? 32'h9999_9999 : acc_shift[31:0];
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status decoded straight from the state register, so Reset clears them
  // without waiting for an edge.
  assign bus.O_Busy = (state_q != IDLE);
  assign bus.O_Done = (state_q == DONE);
  assign bus.O_Bcd  = bcd_q;
  assign bus.O_Ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Drives a saturating and a truncating converter with the same stimulus and
// compares both against a cycle-count model that computes results with plain
// decimal arithmetic. Directed tests add literal expectations.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic [31:0] bin;

  bin2bcd_seq_if bus1 ();
  bin2bcd_seq_if bus0 ();

  assign bus1.I_Start = start;
  assign bus1.I_Bin   = bin;
  assign bus0.I_Start = start;
  assign bus0.I_Bin   = bin;

  bin2bcd_seq #(.SATURATE(1'b1)) dut_sat (.Clk(Clk), .Reset(Reset), .bus(bus1));
  bin2bcd_seq #(.SATURATE(1'b0)) dut_trn (.Clk(Clk), .Reset(Reset), .bus(bus0));

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal result of v as the block must present it.
  function automatic logic [31:0] exp_bcd(input logic [31:0] v, input bit sat);
    longint unsigned x;
    logic [31:0]     r;
    x = longint'(v);
    if (sat && x > 64'd99999999) return 32'h9999_9999;
    x = x % 64'd100000000;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model: a request taken while idle finishes 32 edges later; idle again
  // one edge after that.
  bit          m_busy = 1'b0;
  int          m_count = 0;
  logic [31:0] m_val = '0;
  logic [31:0] m_bcd1 = '0;
  logic [31:0] m_bcd0 = '0;
  logic        m_ovf = 1'b0;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_busy  <= 1'b0;
      m_count <= 0;
      m_val   <= '0;
      m_bcd1  <= '0;
      m_bcd0  <= '0;
      m_ovf   <= 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy  <= 1'b1;
        m_count <= 0;
        m_val   <= bin;
      end
    end else begin
      m_count <= m_count + 1;
      if (m_count + 1 == 32) begin
        m_ovf  <= (m_val > 32'd99999999);
        m_bcd1 <= exp_bcd(m_val, 1'b1);
        m_bcd0 <= exp_bcd(m_val, 1'b0);
      end
      if (m_count + 1 == 33) m_busy <= 1'b0;
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge Clk) begin
    logic exp_done;
    exp_done = m_busy && (m_count == 32);
    check("sat_busy", 32'(bus1.O_Busy), 32'(m_busy));
    check("sat_done", 32'(bus1.O_Done), 32'(exp_done));
    check("sat_bcd",  bus1.O_Bcd, m_bcd1);
    check("sat_ovf",  32'(bus1.O_Ovf), 32'(m_ovf));
    check("trn_busy", 32'(bus0.O_Busy), 32'(m_busy));
    check("trn_done", 32'(bus0.O_Done), 32'(exp_done));
    check("trn_bcd",  bus0.O_Bcd, m_bcd0);
    check("trn_ovf",  32'(bus0.O_Ovf), 32'(m_ovf));
    if (bus1.O_Done) done_cnt++;
  end

  // Present a request just after an edge; returns just after the accepting
  // edge with I_Start low and I_Bin scrambled.
  task automatic start_conv(input logic [31:0] v);
    @(posedge Clk); #2;
    start = 1'b1;
    bin   = v;
    @(posedge Clk); #2;
    start = 1'b0;
    bin   = ~v;
  endtask

  // Counts edges after acceptance until O_Done, bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge Clk); #1;
      edges++;
    end while (!bus1.O_Done && edges < 40);
  endtask

  task automatic conv(input string name, input logic [31:0] v,
                      input logic [31:0] e_sat, input logic [31:0] e_trn,
                      input logic e_ovf);
    int edges;
    start_conv(v);
    wait_done(edges);
    check({name, "_latency"}, 32'(edges), 32'd32);
    check({name, "_busy_at_done"}, 32'(bus1.O_Busy), 32'd1);
    check({name, "_sat_bcd"}, bus1.O_Bcd, e_sat);
    check({name, "_trn_bcd"}, bus0.O_Bcd, e_trn);
    check({name, "_sat_ovf"}, 32'(bus1.O_Ovf), 32'(e_ovf));
    check({name, "_trn_ovf"}, 32'(bus0.O_Ovf), 32'(e_ovf));
    @(posedge Clk); #1;
    check({name, "_idle_after"}, 32'(bus1.O_Busy), 32'd0);
    check({name, "_done_gone"}, 32'(bus1.O_Done), 32'd0);
  endtask

  initial begin
    int base;
    start = 1'b0;
    bin   = '0;
    Reset = 1'b0;
    #1 Reset = 1'b1;
    #2;
    check("rst_busy", 32'(bus1.O_Busy), 32'd0);
    check("rst_done", 32'(bus1.O_Done), 32'd0);
    check("rst_bcd",  bus1.O_Bcd, 32'h0);
    check("rst_ovf",  32'(bus1.O_Ovf), 32'd0);
    #19 Reset = 1'b0;

    // Zero, nominal and boundary values.
    conv("zero",  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    conv("nom",   32'h00BC_614E, 32'h1234_5678, 32'h1234_5678, 1'b0);
    conv("max8",  32'h05F5_E0FF, 32'h9999_9999, 32'h9999_9999, 1'b0);
    conv("ovf",   32'h05F5_E100, 32'h9999_9999, 32'h0000_0000, 1'b1);
    conv("allf",  32'hFFFF_FFFF, 32'h9999_9999, 32'h9496_7295, 1'b1);

    // Requests and input changes while converting must be ignored.
    start_conv(32'h0000_0457);
    base = done_cnt;
    for (int e = 1; e <= 38; e++) begin
      @(posedge Clk); #2;
      if (e == 33) check("iso_idle_after_done", 32'(bus1.O_Busy), 32'd0);
      start = (e == 4 || e == 30 || e == 32);
      bin   = start ? 32'hFFFF_FFFF : 32'h0;
    end
    start = 1'b0;
    check("iso_one_done", 32'(done_cnt - base), 32'd1);
    check("iso_bcd", bus1.O_Bcd, 32'h0000_1111);
    check("iso_still_idle", 32'(bus1.O_Busy), 32'd0);
    conv("after_iso", 32'd7, 32'h0000_0007, 32'h0000_0007, 1'b0);

    // Reset in the middle of a conversion.
    conv("pre_rst", 32'h00BC_614E, 32'h1234_5678, 32'h1234_5678, 1'b0);
    start_conv(32'hFFFF_FFFF);
    repeat (16) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_bcd",  bus1.O_Bcd, 32'h0);
    check("mid_rst_busy", 32'(bus1.O_Busy), 32'd0);
    check("mid_rst_done", 32'(bus1.O_Done), 32'd0);
    base = done_cnt;
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b0;
    repeat (40) @(posedge Clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt - base), 32'd0);
    conv("post_rst", 32'h0000_002A, 32'h0000_0042, 32'h0000_0042, 1'b0);

    repeat (2) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
